// File: rtl/mips_debug_responder.sv
// mips_debug_responder: executes REQ_DATA debug reads and returns each word as LSB/MSB response frames.
module mips_debug_responder #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_DATA          = 32,
  parameter int NB_ADDRESS       = 10,
  parameter int NB_INSTR_DATA    = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_req_valid,
  input  logic [NB_CONTROL_FRAME-1:0] i_req_frame,
  output logic                        o_req_ready,
  output logic                        o_rd_en,
  output logic [NB_ADDRESS-1:0]       o_rd_sel,
  output logic [NB_INSTR_DATA-1:0]    o_rd_index,
  input  logic [NB_DATA-1:0]          i_rd_data,
  output logic                        o_frame_valid,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  input  logic                        i_frame_ack
);
  localparam logic [5:0] REQ_DATA = 6'b000011;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND_LSB, SEND_MSB, ERROR} state_t;
  state_t state;
  logic [2:0] word_cnt;
  logic [NB_INSTR_DATA-1:0] word_msb;
  logic [5:0] req_code;
  logic [NB_ADDRESS-1:0] req_type;
  logic [NB_INSTR_DATA-1:0] req_data;
  logic [2:0] req_count;
  logic use_data;
  logic bad_req;
  assign req_code = i_req_frame[NB_CONTROL_FRAME-1 -: 6];
  assign req_type = i_req_frame[NB_ADDRESS+NB_INSTR_DATA-1 -: NB_ADDRESS];
  assign req_data = i_req_frame[NB_INSTR_DATA-1:0];
  assign o_req_ready = (state == IDLE) & ~i_reset;
  always_comb begin
    req_count = 3'd0;
    case (req_type)
      10'h001, 10'h002, 10'h004, 10'h005, 10'h009, 10'h011, 10'h021, 10'h041: req_count = 3'd1;
      10'h008, 10'h040: req_count = 3'd2;
      10'h020: req_count = 3'd3;
      10'h010: req_count = 3'd4;
      default: req_count = 3'd0;
    endcase
  end
  assign use_data = (req_type == 10'h001) | (req_type == 10'h002) | (req_type == 10'h004);
  assign bad_req  = (req_count == 3'd0) | ((req_type == 10'h004) & (|req_data[NB_INSTR_DATA-1:5]));
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= IDLE;
      word_cnt         <= '0;
      word_msb         <= '0;
      o_rd_en          <= 1'b0;
      o_rd_sel         <= '0;
      o_rd_index       <= '0;
      o_frame_valid    <= 1'b0;
      o_frame_to_blaze <= '0;
    end else begin
      case (state)
        IDLE: if (i_req_valid && req_code == REQ_DATA) begin
          if (bad_req) begin
            state            <= ERROR;
            o_frame_valid    <= 1'b1;
            o_frame_to_blaze <= {6'b111111, req_type, {NB_INSTR_DATA{1'b1}}};
          end else begin
            state      <= READ;
            o_rd_en    <= 1'b1;
            o_rd_sel   <= req_type;
            o_rd_index <= use_data ? req_data : '0;
            word_cnt   <= 3'(req_count - 3'd1);
          end
        end
        READ: begin
          o_rd_en <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          word_msb         <= i_rd_data[NB_DATA-1 -: NB_INSTR_DATA];
          o_frame_valid    <= 1'b1;
          o_frame_to_blaze <= {4'b1100, 1'b0, 1'b0, o_rd_sel, i_rd_data[NB_INSTR_DATA-1:0]};
          state            <= SEND_LSB;
        end
        SEND_LSB: if (i_frame_ack) begin
          o_frame_to_blaze <= {4'b1100, word_cnt == 3'd0, 1'b1, o_rd_sel, word_msb};
          state            <= SEND_MSB;
        end
        SEND_MSB: if (i_frame_ack) begin
          o_frame_valid <= 1'b0;
          if (word_cnt != 3'd0) begin
            word_cnt   <= word_cnt - 3'd1;
            o_rd_index <= o_rd_index + 1'b1;
            o_rd_en    <= 1'b1;
            state      <= READ;
          end else begin
            state <= IDLE;
          end
        end
        ERROR: if (i_frame_ack) begin
          o_frame_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_debug_responder.md
# mips_debug_responder

MIPS-side responder for the MicroBlaze debug control channel. It accepts 32-bit request frames (code[31:26], type[25:16], data[15:0]), executes REQ_DATA requests by reading the selected MIPS debug source through a one-cycle-latency read port, and returns each 32-bit word as two 16-bit response frames (LSB then MSB) over a valid/ack handshake. It sits between the MIPS datapath debug taps and the frame path to the MicroBlaze; all other request codes are consumed silently and handled elsewhere.

## Interface

- NB_CONTROL_FRAME, 32, request/response frame width
- NB_DATA, 32, width of one debug word from the read port
- NB_ADDRESS, 10, request type field width
- NB_INSTR_DATA, 16, request data / response payload width

- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  request frame present
- i_req_frame  in  NB_CONTROL_FRAME  request frame from MicroBlaze side
- o_req_ready  out  1  request accepted this cycle when valid&ready
- o_rd_en  out  1  read strobe to debug sources
- o_rd_sel  out  NB_ADDRESS  source select (request type)
- o_rd_index  out  NB_INSTR_DATA  word index within source
- i_rd_data  in  NB_DATA  read data, valid the cycle after o_rd_en
- o_frame_valid  out  1  response frame valid
- o_frame_to_blaze  out  NB_CONTROL_FRAME  response frame
- i_frame_ack  in  1  response consumed when valid&ack

## Operation

- Request codes: REQ_DATA = 6'b000011; all others accepted and dropped, no response.
- Supported types and word counts: REQ_MEM_DATA 10'h001 (1), REQ_MEM_INSTR 10'h002 (1), REQ_REG 10'h004 (1), REQ_REG_PC 10'h005 (1), REQ_LATCH_FETCH_DATA 10'h008 (2), _CTRL 10'h009 (1), REQ_LATCH_DECO_DATA 10'h010 (4), _CTRL 10'h011 (1), REQ_LATCH_EXEC_DATA 10'h020 (3), _CTRL 10'h021 (1), REQ_LATCH_MEM_DATA 10'h040 (2), _CTRL 10'h041 (1).
- Index: MEM/REG types use request data field as o_rd_index; REG_PC and latch types start at 0 and increment per word.
- REQ_REG with data[15:5] != 0, or unsupported type: single error frame, no read.
- Response frame: [31:26] = {4'b1100, last, half}, half 0 = LSB, 1 = MSB; last = 1 only on MSB frame of final word; [25:16] = echoed request type; [15:0] = word half.
- Error frame: [31:26] = 6'b111111, [25:16] = echoed type, [15:0] = 16'hFFFF.
- FSM: IDLE -> (REQ_DATA valid type) READ -> CAPTURE -> SEND_LSB -> SEND_MSB -> READ (words remain, index+1) or IDLE (last). IDLE -> (bad type/index) ERROR -> IDLE on ack. Non-REQ_DATA: stay IDLE.
- READ: o_rd_en=1 for one cycle. CAPTURE: i_rd_data registered into word buffer.
- Word counter 3 bits, loaded with count-1 at accept, decremented after each SEND_MSB ack.

## Timing

- Reset values: o_frame_valid 0, o_frame_to_blaze 0, o_rd_en 0, o_rd_sel 0, o_rd_index 0, state IDLE, counters 0.
- o_req_ready = (state==IDLE) & ~i_reset; combinational from registered state.
- Accept at cycle T; o_rd_en at T+1; capture at T+2; first frame valid at T+3.
- Frame held stable while o_frame_valid & ~i_frame_ack; transition on ack edge. Ack without valid ignored.
- Back-to-back: SEND_MSB ack at cycle A with words remaining -> o_rd_en at A+1, next LSB valid at A+3; o_frame_valid low during A+1..A+2.
- Last MSB ack at A -> IDLE at A+1, o_req_ready high at A+1.
- Error frame valid cycle after accept.
- Reset anywhere (including mid-transfer, or coincident with valid request or ack): next edge returns all registers to reset values; pending transfer discarded, no further frames.

## Test plan

- Reset then REQ_REG index 5, i_rd_data=32'hA5A5_1234 -> o_rd_sel=10'h004, o_rd_index=5 at T+1; frames 32'hC004_1234 then 32'hCC04_A5A5.
- REQ_LATCH_DECO_DATA, words 32'h1,2,3,4 -> o_rd_index 0..3; 8 frames, only last has code 6'b110011; ready returns cycle after final ack.
- Hold i_frame_ack low 5 cycles on each frame -> frame stable, no duplicates or drops.
- Request type 10'h3FF and REQ_REG index 32 -> single frame {6'b111111, type, 16'hFFFF}; o_rd_en never asserted.
- START code 6'b000001 -> accepted, no o_rd_en, no frame, ready stays 1.
- i_reset during SEND_MSB of word 2 of EXEC_DATA -> o_frame_valid 0 next cycle, IDLE, new REQ_REG completes normally.
